// File: rtl/step_pkg.sv
// Shared constants for the STEP/DIR interface: direction encoding, default
// filter/timeout settings and the microstep position width.
package step_pkg;

   localparam int   POS_W             = 32;
   localparam int   DEF_FILTER_CYCLES = 2;
   localparam int   DEF_TIMEOUT       = 25_000_000;
   localparam logic DIR_POS_LEVEL     = 1'b1;

   // +1 when the direction level matches the positive encoding, otherwise -1.
   function automatic logic [POS_W-1:0] step_delta(input logic dir, input logic dir_pos);
      return (dir == dir_pos) ? POS_W'(1) : '1;
   endfunction

endpackage

// File: rtl/step_input_filter.sv
// Two-flop synchronisers for STEP/DIR plus a high-run counter that turns each
// sufficiently long STEP pulse into exactly one event.
module step_input_filter
   import step_pkg::*;
#(
   parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic step_raw,
   input  logic dir_raw,
   output logic step_evt,
   output logic dir_sync
);

   localparam logic [7:0] RUN_MAX  = 8'(FILTER_CYCLES);
   localparam logic [7:0] RUN_LAST = 8'(FILTER_CYCLES - 1);

   logic [1:0] step_meta;
   logic [1:0] dir_meta;
   logic [7:0] high_cnt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         step_meta <= '0;
         dir_meta  <= '0;
         high_cnt  <= '0;
      end else begin
         // NOTE: non-blocking so each flop takes its pre-edge input; blocking would collapse the synchroniser chain into one stage.
         step_meta <= {step_meta[0], step_raw};
         dir_meta  <= {dir_meta[0], dir_raw};
         if (!step_meta[1]) begin
            high_cnt <= '0;
         end else if (high_cnt != RUN_MAX) begin
            high_cnt <= high_cnt + 8'd1;
         end
      end
   end

   // Saturation at RUN_MAX stops the compare from matching twice in one pulse.
   assign step_evt = step_meta[1] && (high_cnt == RUN_LAST);
   assign dir_sync = dir_meta[1];

endmodule

// File: rtl/step_to_angle.sv
// STEP/DIR receiver: filtered step events drive a signed microstep position,
// a step-period measurement, a motion timeout and a relative-move target.
module step_to_angle
   import step_pkg::*;
#(
   parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
   parameter int   PERIOD_W      = 32,
   parameter int   TIMEOUT       = DEF_TIMEOUT,
   parameter logic DIR_POS       = DIR_POS_LEVEL
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    enable_i,
   input  logic                    step_i,
   input  logic                    dir_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic signed [POS_W-1:0] target_i,
   output logic signed [POS_W-1:0] position_o,
   output logic [PERIOD_W-1:0]     period_o,
   output logic                    period_valid_o,
   output logic                    moving_o,
   output logic                    step_evt_o,
   output logic                    reached_o
);

   localparam logic [PERIOD_W-1:0] PER_MAX      = '1;
   localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT - 1);

   logic                evt;
   logic                dir_sync;
   logic                count_step;
   logic [POS_W-1:0]    delta;
   logic [POS_W-1:0]    pos_q;
   logic [POS_W-1:0]    tgt_q;
   logic [POS_W-1:0]    disp_q;
   logic [POS_W-1:0]    disp_next;
   logic [PERIOD_W-1:0] per_cnt;
   logic [PERIOD_W-1:0] per_inc;

   step_input_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_filter (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .step_raw (step_i),
      .dir_raw  (dir_i),
      .step_evt (evt),
      .dir_sync (dir_sync)
   );

   assign count_step = evt && enable_i;
   assign delta      = step_delta(dir_sync, DIR_POS);
   assign disp_next  = disp_q + delta;
   assign per_inc    = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PERIOD_W'(1);
   assign position_o = pos_q;

   // Period and motion tracking run whether or not position counting is enabled.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         step_evt_o     <= 1'b0;
         per_cnt        <= '0;
         period_o       <= '0;
         period_valid_o <= 1'b0;
         moving_o       <= 1'b0;
      end else begin
         step_evt_o <= evt;
         if (evt) begin
            per_cnt        <= '0;
            period_o       <= per_inc;
            // moving_o is still set only if the previous step fell inside the timeout window.
            period_valid_o <= moving_o;
            moving_o       <= 1'b1;
         end else begin
            per_cnt <= per_inc;
            if (per_cnt == TIMEOUT_LAST) begin
               moving_o       <= 1'b0;
               period_valid_o <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pos_q <= '0;
      end else if (clear_i) begin
         pos_q <= '0;
      end else if (count_step) begin
         pos_q <= pos_q + delta;
      end
   end

   // A load discards any coincident step from the displacement but not from the position.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tgt_q     <= '0;
         disp_q    <= '0;
         reached_o <= 1'b0;
      end else if (load_i) begin
         tgt_q     <= target_i;
         disp_q    <= '0;
         reached_o <= (target_i == '0);
      end else if (count_step) begin
         disp_q    <= disp_next;
         reached_o <= (disp_next == tgt_q);
      end
   end

endmodule

// File: tb/tb_step_to_angle.sv
// Directed bench for step_to_angle: a behavioural model built from the sample
// history of step_i is compared against the DUT every cycle, plus literal checks.
module tb_step_to_angle;

   localparam int FC = 2;
   localparam int PW = 32;
   localparam int TO = 100;

   logic               clk_i;
   logic               reset_n_i;
   logic               enable_i;
   logic               step_i;
   logic               dir_i;
   logic               clear_i;
   logic               load_i;
   logic signed [31:0] target_i;
   logic signed [31:0] position_o;
   logic [PW-1:0]      period_o;
   logic               period_valid_o;
   logic               moving_o;
   logic               step_evt_o;
   logic               reached_o;

   logic               preset_req;
   logic [31:0]        preset_val;

   int tests;
   int fails;

   step_to_angle #(
      .FILTER_CYCLES(FC),
      .PERIOD_W     (PW),
      .TIMEOUT      (TO),
      .DIR_POS      (1'b1)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .enable_i      (enable_i),
      .step_i        (step_i),
      .dir_i         (dir_i),
      .clear_i       (clear_i),
      .load_i        (load_i),
      .target_i      (target_i),
      .position_o    (position_o),
      .period_o      (period_o),
      .period_valid_o(period_valid_o),
      .moving_o      (moving_o),
      .step_evt_o    (step_evt_o),
      .reached_o     (reached_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Model state: sh/dh hold the raw step/dir samples of past edges (bit 0 = latest).
   typedef struct packed {
      logic [7:0]  sh;
      logic [7:0]  dh;
      logic [63:0] edge_no;
      logic [63:0] anchor;
      logic [31:0] pos;
      logic [31:0] period;
      logic [31:0] tgt;
      logic [31:0] disp;
      logic        valid;
      logic        moving;
      logic        evt;
      logic        reached;
   } model_t;

   model_t m;

   // A step is reported FC+2 edges after the first high sample of a run of at least FC highs.
   function automatic model_t model_next(model_t c, logic stp, logic d, logic en, logic clr,
                                         logic ld, logic [31:0] tg, logic pre, logic [31:0] pre_val);
      model_t      n;
      logic        hit;
      logic [31:0] dlt;
      logic [63:0] since;
      n   = c;
      hit = !c.sh[FC+1];
      for (int i = 1; i <= FC; i++) hit = hit && c.sh[i];
      dlt       = c.dh[1] ? 32'd1 : 32'hFFFF_FFFF;
      n.edge_no = c.edge_no + 64'd1;
      since     = n.edge_no - c.anchor;
      n.evt     = hit;
      if (hit) begin
         n.period = (since > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : since[31:0];
         n.valid  = c.moving;
         n.moving = 1'b1;
         n.anchor = n.edge_no;
      end else if (since == 64'(TO)) begin
         n.moving = 1'b0;
         n.valid  = 1'b0;
      end
      if (clr) n.pos = '0;
      else if (hit && en) n.pos = c.pos + dlt;
      if (ld) begin
         n.tgt     = tg;
         n.disp    = '0;
         n.reached = (tg == '0);
      end else if (hit && en) begin
         n.disp    = c.disp + dlt;
         n.reached = (n.disp == c.tgt);
      end
      if (pre) n.pos = pre_val;
      n.sh = {c.sh[6:0], stp};
      n.dh = {c.dh[6:0], d};
      return n;
   endfunction

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) m <= '0;
      else m <= model_next(m, step_i, dir_i, enable_i, clear_i, load_i, target_i, preset_req, preset_val);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every clock advance goes through here so the model is compared on every cycle.
   task automatic tick();
      @(negedge clk_i);
      check("step_evt", 32'(step_evt_o), 32'(m.evt));
      check("position", position_o, m.pos);
      check("period", period_o, m.period);
      check("period_valid", 32'(period_valid_o), 32'(m.valid));
      check("moving", 32'(moving_o), 32'(m.moving));
      check("reached", 32'(reached_o), 32'(m.reached));
   endtask

   task automatic pulse(input int width, input int spacing, input logic d,
                        output int evts, output int first_at);
      evts     = 0;
      first_at = -1;
      dir_i    = d;
      step_i   = 1'b1;
      for (int i = 0; i < spacing; i++) begin
         tick();
         if (step_evt_o) begin
            evts++;
            if (first_at < 0) first_at = i + 1;
         end
         if (i == width - 1) step_i = 1'b0;
      end
   endtask

   // 4-sample pulse with clear/load held only in the cycle that registers its event.
   task automatic coincident(input logic clr, input logic ld, input logic [31:0] tg, output logic evt_seen);
      dir_i  = 1'b1;
      step_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      clear_i  = clr;
      load_i   = ld;
      target_i = tg;
      tick();
      evt_seen = step_evt_o;
      clear_i  = 1'b0;
      load_i   = 1'b0;
      step_i   = 1'b0;
      for (int i = 0; i < 6; i++) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int       n;
      int       f;
      int       total;
      logic     seen;
      tests      = 0;
      fails      = 0;
      reset_n_i  = 1'b0;
      enable_i   = 1'b1;
      step_i     = 1'b0;
      dir_i      = 1'b1;
      clear_i    = 1'b0;
      load_i     = 1'b0;
      target_i   = '0;
      preset_req = 1'b0;
      preset_val = '0;
      tick();
      tick();
      reset_n_i = 1'b1;
      tick();
      check("rst_position", position_o, 32'd0);
      check("rst_period", period_o, 32'd0);
      check("rst_flags", {28'd0, period_valid_o, moving_o, step_evt_o, reached_o}, 32'd0);

      // Five clean pulses, 20 cycles apart.
      pulse(4, 20, 1'b1, n, f);
      check("first_evt_edge", f, 32'd4);
      check("first_valid", 32'(period_valid_o), 32'd0);
      check("first_moving", 32'(moving_o), 32'd1);
      total = n;
      pulse(4, 20, 1'b1, n, f);
      check("second_valid", 32'(period_valid_o), 32'd1);
      total += n;
      for (int k = 0; k < 3; k++) begin
         pulse(4, 20, 1'b1, n, f);
         total += n;
      end
      check("five_evts", total, 32'd5);
      check("five_position", position_o, 32'd5);
      check("five_period", period_o, 32'd20);
      check("five_valid", 32'(period_valid_o), 32'd1);

      // One-sample glitches are dropped, a two-sample pulse is accepted.
      total = 0;
      for (int k = 0; k < 3; k++) begin
         pulse(1, 10, 1'b1, n, f);
         total += n;
      end
      check("glitch_evts", total, 32'd0);
      check("glitch_position", position_o, 32'd5);
      pulse(2, 10, 1'b1, n, f);
      check("short_evts", n, 32'd1);
      check("short_position", position_o, 32'd6);

      // Relative target of -3 reached with negative steps, then overshot.
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clear_position", position_o, 32'd0);
      load_i   = 1'b1;
      target_i = -3;
      tick();
      load_i = 1'b0;
      check("load_reached", 32'(reached_o), 32'd0);
      for (int k = 0; k < 3; k++) pulse(4, 10, 1'b0, n, f);
      check("target_reached", 32'(reached_o), 32'd1);
      check("target_position", position_o, 32'hFFFF_FFFD);
      pulse(4, 10, 1'b0, n, f);
      check("overshoot_reached", 32'(reached_o), 32'd0);
      check("overshoot_position", position_o, 32'hFFFF_FFFC);

      // Timeout: last event is 6 cycles back after the third pulse.
      for (int k = 0; k < 3; k++) pulse(4, 10, 1'b1, n, f);
      for (int k = 7; k <= 99; k++) tick();
      check("moving_before_to", 32'(moving_o), 32'd1);
      tick();
      check("moving_after_to", 32'(moving_o), 32'd0);
      check("valid_after_to", 32'(period_valid_o), 32'd0);
      check("period_held", period_o, 32'd10);
      pulse(4, 10, 1'b1, n, f);
      check("restart_valid", 32'(period_valid_o), 32'd0);
      check("restart_moving", 32'(moving_o), 32'd1);
      pulse(4, 10, 1'b1, n, f);
      check("second_restart_valid", 32'(period_valid_o), 32'd1);
      check("second_restart_period", period_o, 32'd10);
      check("restart_position", position_o, 32'd1);

      // clear+load on the event cycle: position 0, step not counted in displacement.
      coincident(1'b1, 1'b1, 32'd2, seen);
      check("cl_evt", 32'(seen), 32'd1);
      check("cl_position", position_o, 32'd0);
      pulse(4, 10, 1'b1, n, f);
      check("cl_reached_1", 32'(reached_o), 32'd0);
      pulse(4, 10, 1'b1, n, f);
      check("cl_reached_2", 32'(reached_o), 32'd1);

      // load alone on the event cycle: position counts it, displacement does not.
      coincident(1'b0, 1'b1, 32'd1, seen);
      check("ld_position", position_o, 32'd3);
      check("ld_reached_0", 32'(reached_o), 32'd0);
      pulse(4, 10, 1'b1, n, f);
      check("ld_reached_1", 32'(reached_o), 32'd1);
      check("ld_position_2", position_o, 32'd4);

      // Wrap from the largest positive position.
      force dut.pos_q = 32'h7FFF_FFFF;
      preset_val = 32'h7FFF_FFFF;
      preset_req = 1'b1;
      tick();
      release dut.pos_q;
      preset_req = 1'b0;
      tick();
      check("preset_position", position_o, 32'h7FFF_FFFF);
      pulse(4, 10, 1'b1, n, f);
      check("wrap_position", position_o, 32'h8000_0000);

      // Disabled counting: events still pulse and keep motion alive.
      enable_i = 1'b0;
      total    = 0;
      for (int k = 0; k < 3; k++) begin
         pulse(4, 10, 1'b1, n, f);
         total += n;
      end
      check("dis_evts", total, 32'd3);
      check("dis_position", position_o, 32'h8000_0000);
      check("dis_moving", 32'(moving_o), 32'd1);
      enable_i = 1'b1;

      // Reset in the middle of a pulse: counted once after full latency from release.
      dir_i  = 1'b1;
      step_i = 1'b1;
      tick();
      tick();
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      total     = 0;
      f         = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (step_evt_o) begin
            total++;
            if (f < 0) f = i + 1;
         end
         if (i == 5) step_i = 1'b0;
      end
      check("midrst_evts", total, 32'd1);
      check("midrst_latency", f, 32'd4);
      check("midrst_position", position_o, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
